// File: rtl/ycbcr2rgb.sv
// BT.601 studio-range YCbCr -> RGB, three register stages (offset, multiply, sum+clamp)
// with a valid/ready handshake that stalls the whole pipeline on backpressure.
module ycbcr2rgb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] Y,
  input  logic [7:0] Cb,
  input  logic [7:0] Cr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       out_clip
);

  logic w_adv;

  logic               r_vld_p0;
  logic signed [8:0]  r_yo_p0;
  logic signed [8:0]  r_cbo_p0;
  logic signed [8:0]  r_cro_p0;

  logic               r_vld_p1;
  logic signed [19:0] r_py_p1;
  logic signed [19:0] r_prr_p1;
  logic signed [19:0] r_pgb_p1;
  logic signed [19:0] r_pgr_p1;
  logic signed [19:0] r_pbb_p1;

  logic               r_vld_p2;
  logic [7:0]         r_r_p2;
  logic [7:0]         r_g_p2;
  logic [7:0]         r_b_p2;
  logic               r_clip_p2;

  logic signed [19:0] w_yo_x;
  logic signed [19:0] w_cbo_x;
  logic signed [19:0] w_cro_x;
  logic signed [20:0] w_py_x;
  logic signed [20:0] w_prr_x;
  logic signed [20:0] w_pgb_x;
  logic signed [20:0] w_pgr_x;
  logic signed [20:0] w_pbb_x;
  logic signed [20:0] w_sr;
  logic signed [20:0] w_sg;
  logic signed [20:0] w_sb;
  logic [8:0]         w_rc;
  logic [8:0]         w_gc;
  logic [8:0]         w_bc;

  // Returns {clipped, channel}: floor(s/256) saturated to 0..255.
  function automatic logic [8:0] clamp8(input logic signed [20:0] s);
    logic signed [20:0] q;
    q = s >>> 8;
    if (q < 21'sd0)
      return {1'b1, 8'd0};
    else if (q > 21'sd255)
      return {1'b1, 8'hFF};
    else
      return {1'b0, q[7:0]};
  endfunction

  assign w_adv    = !r_vld_p2 || out_ready;
  assign in_ready = w_adv;

  assign w_yo_x  = {{11{r_yo_p0[8]}},  r_yo_p0};
  assign w_cbo_x = {{11{r_cbo_p0[8]}}, r_cbo_p0};
  assign w_cro_x = {{11{r_cro_p0[8]}}, r_cro_p0};

  assign w_py_x  = {r_py_p1[19],  r_py_p1};
  assign w_prr_x = {r_prr_p1[19], r_prr_p1};
  assign w_pgb_x = {r_pgb_p1[19], r_pgb_p1};
  assign w_pgr_x = {r_pgr_p1[19], r_pgr_p1};
  assign w_pbb_x = {r_pbb_p1[19], r_pbb_p1};

  assign w_sr = w_py_x + w_prr_x + 21'sd128;
  assign w_sg = w_py_x - w_pgb_x - w_pgr_x + 21'sd128;
  assign w_sb = w_py_x + w_pbb_x + 21'sd128;

  assign w_rc = clamp8(w_sr);
  assign w_gc = clamp8(w_sg);
  assign w_bc = clamp8(w_sb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p0  <= 1'b0;
      r_yo_p0   <= '0;
      r_cbo_p0  <= '0;
      r_cro_p0  <= '0;
      r_vld_p1  <= 1'b0;
      r_py_p1   <= '0;
      r_prr_p1  <= '0;
      r_pgb_p1  <= '0;
      r_pgr_p1  <= '0;
      r_pbb_p1  <= '0;
      r_vld_p2  <= 1'b0;
      r_r_p2    <= '0;
      r_g_p2    <= '0;
      r_b_p2    <= '0;
      r_clip_p2 <= 1'b0;
    end else if (w_adv) begin
      // stage 1: remove studio-range offsets
      r_vld_p0  <= in_valid;
      r_yo_p0   <= $signed({1'b0, Y})  - 9'sd16;
      r_cbo_p0  <= $signed({1'b0, Cb}) - 9'sd128;
      r_cro_p0  <= $signed({1'b0, Cr}) - 9'sd128;
      // stage 2: coefficient products (x256 fixed point)
      r_vld_p1  <= r_vld_p0;
      r_py_p1   <= w_yo_x  * 20'sd298;
      r_prr_p1  <= w_cro_x * 20'sd409;
      r_pgb_p1  <= w_cbo_x * 20'sd100;
      r_pgr_p1  <= w_cro_x * 20'sd208;
      r_pbb_p1  <= w_cbo_x * 20'sd516;
      // stage 3: round, scale down, clamp
      r_vld_p2  <= r_vld_p1;
      r_r_p2    <= w_rc[7:0];
      r_g_p2    <= w_gc[7:0];
      r_b_p2    <= w_bc[7:0];
      r_clip_p2 <= w_rc[8] | w_gc[8] | w_bc[8];
    end
  end

  assign out_valid = r_vld_p2;
  assign R         = r_r_p2;
  assign G         = r_g_p2;
  assign B         = r_b_p2;
  assign out_clip  = r_clip_p2;

endmodule

// File: doc/ycbcr2rgb.md
# ycbcr2rgb

Pipelined BT.601 studio-range YCbCr-to-RGB converter, the decode-side counterpart of the front-end RGB-to-YCbCr stage. It takes 8-bit Y/Cb/Cr pixels from the processing datapath and produces 8-bit R/G/B for display and write-back. It uses fixed-point coefficients scaled by 256, rounds, and clamps each channel. A valid/ready handshake with full-pipeline stall on backpressure lets it sit between stream stages without a side FIFO.

## Interface
Parameters:
- none; coefficients fixed: 298 (Y), 409 (Cr→R), 100 (Cb→G), 208 (Cr→G), 516 (Cb→B); offsets 16 (Y), 128 (Cb/Cr)

Ports:
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  Y/Cb/Cr carry a pixel this cycle
- in_ready  output  1  block accepts a pixel this cycle
- Y  input  8  luma, unsigned
- Cb  input  8  blue-difference chroma, unsigned
- Cr  input  8  red-difference chroma, unsigned
- out_valid  output  1  R/G/B/out_clip hold a pixel
- out_ready  input  1  downstream accepts a pixel
- R, G, B  output  8 each  clamped colour channels
- out_clip  output  1  at least one channel of this pixel was clamped

## Operation
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- `adv = !out_valid || out_ready`. When `adv` is 1, all three stages shift together. When `adv` is 0, every stage register holds.
- `in_ready = adv`, driven combinationally. There is no combinational path from Y/Cb/Cr to any output.
- Stage 1 registers signed 9-bit offsets: `yo = Y-16`, `cbo = Cb-128`, `cro = Cr-128`, plus `v1 = in_valid`.
- Stage 2 registers signed 20-bit products: `py = 298*yo`, `prr = 409*cro`, `pgb = 100*cbo`, `pgr = 208*cro`, `pbb = 516*cbo`, plus `v2 = v1`.
- Stage 3 computes signed 21-bit sums, then registers the results:
  - `sr = py + prr + 128`
  - `sg = py - pgb - pgr + 128`
  - `sb = py + pbb + 128`
  - Each sum is arithmetic-shifted right by 8 (floor). If the result is < 0, the channel is 0. If it is > 255, the channel is 255. Otherwise the channel is the low 8 bits.
  - `out_clip` is the OR of the three clamp conditions.
  - Registered outputs are R/G/B/out_clip, with `out_valid = v2`.
- Bubbles (stage valid = 0) flow through and are not collapsed. Data registers may update on bubbles; consumers must ignore R/G/B whenever `out_valid` = 0.
- Ordering is strictly FIFO. No pixel is dropped or duplicated across any stall pattern.

## Timing
- Reset (async assert, sync-safe deassert): v1, v2, out_valid, R, G, B and out_clip all become 0. All data registers become 0. in_ready reads 1 immediately, because out_valid = 0.
- Latency with no stall: a pixel accepted at edge N appears with out_valid = 1 after edge N+2, i.e. 3 register stages. Throughput is 1 pixel/clk.
- Stall: if out_valid = 1 and out_ready = 0, then in_ready = 0 the same cycle, and every register, including the valid bits, holds until out_ready returns to 1.
- in_valid = 0 while adv = 1 inserts a bubble (v1 ← 0).
- Simultaneous out transfer and in transfer in one cycle is legal and is the steady state.
- Reset mid-stream discards every in-flight pixel. out_valid drops asynchronously with rst_n.
- Y/Cb/Cr outside studio range (e.g. Y < 16, Cb > 240) are valid inputs, handled only by the clamp.

## Test plan
- Reset, then Y/Cb/Cr = 16/128/128 with out_ready = 1 → three cycles later R/G/B = 0/0/0, out_clip = 0; then 235/128/128 → 255/255/255, out_clip = 0.
- 81/90/240 → R/G/B = 255/0/0, out_clip = 1. Then 255/255/255 → 255/125/255, out_clip = 1. Then 0/128/128 → 0/0/0, out_clip = 1.
- Stream 64 random pixels back-to-back with out_ready = 1 → exactly 64 outputs, one per clk starting at latency 3, each bit-matching the integer reference model.
- Hold out_ready = 0 while pushing 5 pixels with in_valid = 1 → only 3 pixels are accepted, then in_ready = 0 and outputs stay frozen on pixel 1. Release out_ready → pixels 1..5 emerge in order, with no loss or duplicate.
- Random in_valid/out_ready toggling (50% each) over 1000 pixels → output sequence equals the model sequence, and out_valid never asserts without a matching accepted input.
- Assert rst_n = 0 mid-stream with 3 pixels in flight → out_valid goes 0 without waiting for a clock edge and R/G/B go to 0. After release, the first new pixel emerges 3 cycles after acceptance and no pre-reset pixel appears.
